// File: rtl/spi_pkg.sv
// Shared definitions for the SPI port arbiter: FSM encoding, PmodACL
// (ADXL345) command words and default timing values.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // ADXL345 command words: {R/W, MB, addr[5:0], data[7:0]}
    localparam logic [15:0] CMD_POWER_CTL   = 16'h2D08;
    localparam logic [15:0] CMD_BW_RATE     = 16'h2C08;
    localparam logic [15:0] CMD_DATA_FORMAT = 16'h3100;
    localparam logic [15:0] CMD_READ_Y0     = 16'hB400;
    localparam logic [15:0] CMD_READ_Y1     = 16'hB500;

    // Idle time between bus transactions and the done-wait limit, in clk cycles.
    localparam int DEFAULT_GAP_CYCLES     = 4096;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

    // Terminal value of a 16-bit counter that must run for 'cycles' cycles (1..65536).
    function automatic logic [15:0] count_last(input int cycles);
        return 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/spi_port_arbiter_if.sv
// Requester-side and SPIinterface-side signals of the port arbiter.
// slave = the arbiter itself, master = whatever surrounds it.
interface spi_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_transmit;
    logic [16*NUM_REQ-1:0] req_txdata;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_timeout;
    logic [7:0]            req_rxdata;
    logic                  spi_transmit;
    logic [15:0]           spi_txdata;
    logic [7:0]            spi_rxdata;
    logic                  spi_done;
    logic [NUM_REQ-1:0]    ss_n;
    logic                  busy;

    modport slave (
        input  req_transmit, req_txdata, spi_rxdata, spi_done,
        output req_done, req_timeout, req_rxdata, spi_transmit, spi_txdata, ss_n, busy
    );

    modport master (
        output req_transmit, req_txdata, spi_rxdata, spi_done,
        input  req_done, req_timeout, req_rxdata, spi_transmit, spi_txdata, ss_n, busy
    );
endinterface

// File: rtl/spi_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past rr_ptr
// and wraps, so the most recently served requester has lowest priority.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      grant,
    output logic               valid
);

    // Walk the rotated order backwards so the nearest pending requester is written last and wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (pending[IW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
                valid = 1'b1;
                grant = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_port_arbiter.sv
// Shares one SPIinterface between NUM_REQ requesters: latches one command
// word per requester, grants the bus round-robin, drives the matching
// device select, reports done/timeout, and enforces an idle gap afterwards.
module spi_port_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic              clk,
    input logic              rst,
    spi_port_arbiter_if.slave bus
);

    localparam int          IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] GAP_LAST     = count_last(GAP_CYCLES);
    localparam logic [15:0] TIMEOUT_LAST = count_last(TIMEOUT_CYCLES);

    state_t             state_reg;
    logic [NUM_REQ-1:0] pending_reg;
    logic [15:0]        shadow_reg [NUM_REQ];
    logic [IW-1:0]      grant_reg;
    logic [IW-1:0]      rr_ptr_reg;
    logic [15:0]        timeout_cnt_reg;
    logic [15:0]        gap_cnt_reg;
    logic               spi_transmit_reg;
    logic [15:0]        spi_txdata_reg;
    logic [NUM_REQ-1:0] ss_n_reg;
    logic [NUM_REQ-1:0] req_done_reg;
    logic [NUM_REQ-1:0] req_timeout_reg;
    logic [7:0]         req_rxdata_reg;

    logic [IW-1:0]      arb_grant;
    logic               arb_valid;
    logic [NUM_REQ-1:0] grant_mask;
    logic               finish;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .pending (pending_reg),
        .rr_ptr  (rr_ptr_reg),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    assign grant_mask = NUM_REQ'(1) << grant_reg;
    // The current transaction ends this edge, by spi_done or by timeout.
    assign finish = (state_reg == ST_WAIT) &&
                    (bus.spi_done || (timeout_cnt_reg == TIMEOUT_LAST));

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        // Capture a request only while not pending; completion takes priority over a same-edge capture.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pending_reg[gi] <= 1'b0;
                shadow_reg[gi]  <= '0;
            end else if (finish && grant_mask[gi]) begin
                pending_reg[gi] <= 1'b0;
            end else if (bus.req_transmit[gi] && !pending_reg[gi]) begin
                pending_reg[gi] <= 1'b1;
                shadow_reg[gi]  <= bus.req_txdata[16*gi +: 16];
            end
        end
    end

    // Sequencer: grant, start pulse, wait for done or timeout, then hold the bus idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            grant_reg        <= '0;
            rr_ptr_reg       <= '0;
            timeout_cnt_reg  <= '0;
            gap_cnt_reg      <= '0;
            spi_transmit_reg <= 1'b0;
            spi_txdata_reg   <= '0;
            ss_n_reg         <= '1;
            req_done_reg     <= '0;
            req_timeout_reg  <= '0;
            req_rxdata_reg   <= '0;
        end else begin
            spi_transmit_reg <= 1'b0;
            req_done_reg     <= '0;
            req_timeout_reg  <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_reg      <= arb_grant;
                        spi_txdata_reg <= shadow_reg[arb_grant];
                        ss_n_reg       <= ~(NUM_REQ'(1) << arb_grant);
                        state_reg      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Select went low last edge, so it leads the start pulse by a cycle.
                    spi_transmit_reg <= 1'b1;
                    timeout_cnt_reg  <= '0;
                    state_reg        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.spi_done) begin
                        req_rxdata_reg <= bus.spi_rxdata;
                        req_done_reg   <= grant_mask;
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        req_timeout_reg <= grant_mask;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
                    if (finish) begin
                        rr_ptr_reg  <= grant_reg;
                        ss_n_reg    <= '1;
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.spi_transmit = spi_transmit_reg;
    assign bus.spi_txdata   = spi_txdata_reg;
    assign bus.ss_n         = ss_n_reg;
    assign bus.req_done     = req_done_reg;
    assign bus.req_timeout  = req_timeout_reg;
    assign bus.req_rxdata   = req_rxdata_reg;
    assign bus.busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spi_port_arbiter.sv
// Directed bench for spi_port_arbiter with a behavioural SPIinterface model
// and a scoreboard of expected completions.
module tb_spi_port_arbiter;
    import spi_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int GAP     = 4096;
    localparam int TMO     = 100;
    localparam int SPI_LAT = 40;
    localparam int BUDGET  = GAP + 2000;

    typedef struct {
        bit         is_timeout;
        int         idx;
        logic [7:0] rx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    spi_port_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_txn = 0;
    int          cyc = 0;
    int          n_done_pulses = 0;
    int          n_to_pulses = 0;
    exp_t        exp_q[$];
    logic [15:0] log_tx[$];
    logic [1:0]  log_ss[$];
    int          log_cyc[$];
    bit          spi_mute = 1'b0;
    int          stray_req = 0;
    int          stray_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (|bus.req_done)    n_done_pulses <= n_done_pulses + 1;
        if (|bus.req_timeout) n_to_pulses   <= n_to_pulses + 1;
    end

    // SPIinterface model: logs each start pulse, answers SPI_LAT cycles later
    // with rxdata = txdata[15:8] ^ 8'hEE, or never when muted.
    initial begin : spi_model
        int          cnt;
        logic [15:0] cur_tx;
        cnt = 0;
        cur_tx = '0;
        bus.spi_done = 1'b0;
        bus.spi_rxdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.spi_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.spi_rxdata = cur_tx[15:8] ^ 8'hEE;
                    bus.spi_done = 1'b1;
                end
            end else if (bus.spi_transmit) begin
                log_tx.push_back(bus.spi_txdata);
                log_ss.push_back(bus.ss_n);
                log_cyc.push_back(cyc);
                cur_tx = bus.spi_txdata;
                if (!spi_mute) cnt = SPI_LAT;
            end else if (stray_req != stray_ack) begin
                bus.spi_rxdata = 8'h77;
                bus.spi_done = 1'b1;
                stray_ack = stray_req;
            end
        end
    end

    initial begin : watchdog
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next done/timeout pulse and compare it with the scoreboard head.
    task automatic expect_completion(input string tag, output int at_cyc);
        exp_t       e;
        int         waited;
        logic [1:0] mask;
        waited = 0;
        at_cyc = -1;
        @(negedge clk);
        while (bus.req_done == '0 && bus.req_timeout == '0 && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " pulse seen"}, 32'(bus.req_done != '0 || bus.req_timeout != '0), 32'd1);
        at_cyc = cyc;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s scoreboard: observed completion required none", tag);
        end else begin
            e = exp_q.pop_front();
            mask = 2'(1) << e.idx;
            n_txn++;
            $display("txn %0d %s: req %0d %s rx=%h (cycle %0d)", n_txn, tag, e.idx,
                     e.is_timeout ? "timeout" : "done", bus.req_rxdata, cyc);
            check({tag, " req_done"},    32'(bus.req_done),    32'(e.is_timeout ? 2'b00 : mask));
            check({tag, " req_timeout"}, 32'(bus.req_timeout), 32'(e.is_timeout ? mask : 2'b00));
            check({tag, " req_rxdata"},  32'(bus.req_rxdata),  32'(e.rx));
        end
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (bus.busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin : main
        int c;
        int n;
        int li;
        int base_done;
        int base_to;

        bus.req_transmit = '0;
        bus.req_txdata = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst ss_n",         32'(bus.ss_n),         32'h3);
        check("rst busy",         32'(bus.busy),         32'h0);
        check("rst spi_transmit", 32'(bus.spi_transmit), 32'h0);
        check("rst spi_txdata",   32'(bus.spi_txdata),   32'h0);
        check("rst req_done",     32'(bus.req_done),     32'h0);
        check("rst req_timeout",  32'(bus.req_timeout),  32'h0);
        check("rst req_rxdata",   32'(bus.req_rxdata),   32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single requester
        li = log_tx.size();
        bus.req_transmit = 2'b01;
        bus.req_txdata = {16'h0000, CMD_READ_Y0};
        exp_q.push_back('{1'b0, 0, 8'h5A});
        @(negedge clk);
        bus.req_transmit = 2'b00;
        check("t1 ss_n at capture", 32'(bus.ss_n), 32'h3);
        @(negedge clk);
        check("t1 ss_n at grant",        32'(bus.ss_n),         32'h2);
        check("t1 spi_txdata",           32'(bus.spi_txdata),   32'hB400);
        check("t1 busy",                 32'(bus.busy),         32'h1);
        check("t1 no early spi_transmit", 32'(bus.spi_transmit), 32'h0);
        @(negedge clk);
        check("t1 spi_transmit", 32'(bus.spi_transmit), 32'h1);
        expect_completion("t1", c);
        check("t1 ss_n released", 32'(bus.ss_n), 32'h3);
        wait_idle("t1", n);
        check("t1 gap cycles", 32'(n), 32'(GAP));

        // Simultaneous requests, rr_ptr = 0: req1 first
        li = log_tx.size();
        bus.req_transmit = 2'b11;
        bus.req_txdata = {CMD_READ_Y1, CMD_POWER_CTL};
        exp_q.push_back('{1'b0, 1, 8'h5B});
        exp_q.push_back('{1'b0, 0, 8'hC3});
        @(negedge clk);
        bus.req_transmit = 2'b00;
        expect_completion("t2a", c);
        expect_completion("t2b", c);
        check("t2 first ss_n",  32'(log_ss[li]),     32'h1);
        check("t2 first tx",    32'(log_tx[li]),     32'hB500);
        check("t2 second ss_n", 32'(log_ss[li+1]),   32'h2);
        check("t2 second tx",   32'(log_tx[li+1]),   32'h2D08);
        check("t2 spacing", 32'((log_cyc[li+1] - log_cyc[li]) >= GAP + 2), 32'd1);
        wait_idle("t2", n);

        // Fairness: both hold req_transmit high, 6 transactions alternate 1,0,...
        li = log_tx.size();
        base_done = n_done_pulses;
        bus.req_transmit = 2'b11;
        bus.req_txdata = {CMD_READ_Y1, CMD_READ_Y0};
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_q.push_back('{1'b0, 1, 8'h5B});
            else            exp_q.push_back('{1'b0, 0, 8'h5A});
        end
        for (int k = 0; k < 6; k++) begin
            expect_completion("t3", c);
            if (k == 4) bus.req_transmit[1] = 1'b0;
            if (k == 5) bus.req_transmit[0] = 1'b0;
        end
        wait_idle("t3", n);
        repeat (20) @(negedge clk);
        check("t3 stays idle", 32'(bus.busy), 32'h0);
        check("t3 done pulses", 32'(n_done_pulses - base_done), 32'd6);
        for (int k = 0; k < 6; k++)
            check("t3 grant order", 32'(log_ss[li+k]), (k % 2 == 0) ? 32'h1 : 32'h2);

        // Timeout
        spi_mute = 1'b1;
        li = log_tx.size();
        base_done = n_done_pulses;
        bus.req_transmit = 2'b01;
        bus.req_txdata = {16'h0000, CMD_BW_RATE};
        exp_q.push_back('{1'b1, 0, 8'h5A});
        @(negedge clk);
        bus.req_transmit = 2'b00;
        expect_completion("t4", c);
        check("t4 timeout latency", 32'(c - log_cyc[li]), 32'(TMO));
        check("t4 no done", 32'(n_done_pulses - base_done), 32'd0);
        wait_idle("t4", n);
        check("t4 gap cycles", 32'(n), 32'(GAP));
        spi_mute = 1'b0;

        // Async reset mid-WAIT
        base_done = n_done_pulses;
        base_to = n_to_pulses;
        bus.req_transmit = 2'b10;
        bus.req_txdata = {CMD_DATA_FORMAT, 16'h0000};
        @(negedge clk);
        bus.req_transmit = 2'b00;
        for (int i = 0; i < 10 && !bus.spi_transmit; i++) @(negedge clk);
        check("t5 issued", 32'(bus.spi_transmit), 32'h1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5 ss_n on reset",       32'(bus.ss_n),       32'h3);
        check("t5 busy on reset",       32'(bus.busy),       32'h0);
        check("t5 spi_txdata on reset", 32'(bus.spi_txdata), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t5 no done",     32'(n_done_pulses - base_done), 32'd0);
        check("t5 no timeout",  32'(n_to_pulses - base_to),     32'd0);
        check("t5 rxdata reset", 32'(bus.req_rxdata), 32'h0);
        li = log_tx.size();
        bus.req_transmit = 2'b10;
        bus.req_txdata = {CMD_READ_Y1, 16'h0000};
        exp_q.push_back('{1'b0, 1, 8'h5B});
        @(negedge clk);
        bus.req_transmit = 2'b00;
        expect_completion("t5", c);
        check("t5 ss_n after reset", 32'(log_ss[li]), 32'h1);
        wait_idle("t5", n);

        // Stray spi_done in IDLE, duplicate request while pending, stray in GAP
        base_done = n_done_pulses;
        stray_req++;
        repeat (5) @(negedge clk);
        check("t6 idle stray done", 32'(n_done_pulses - base_done), 32'd0);
        check("t6 idle stray rx",   32'(bus.req_rxdata), 32'h5B);
        check("t6 idle stray busy", 32'(bus.busy), 32'h0);
        check("t6 idle stray ss_n", 32'(bus.ss_n), 32'h3);
        li = log_tx.size();
        bus.req_transmit = 2'b10;
        bus.req_txdata = {CMD_DATA_FORMAT, 16'h0000};
        exp_q.push_back('{1'b0, 1, 8'hDF});
        @(negedge clk);
        bus.req_transmit = 2'b01;
        bus.req_txdata = {CMD_DATA_FORMAT, CMD_READ_Y0};
        exp_q.push_back('{1'b0, 0, 8'h5A});
        @(negedge clk);
        bus.req_txdata = {CMD_DATA_FORMAT, CMD_POWER_CTL};
        @(negedge clk);
        bus.req_transmit = 2'b00;
        expect_completion("t6a", c);
        repeat (10) @(negedge clk);
        stray_req++;
        repeat (5) @(negedge clk);
        check("t6 gap stray done", 32'(n_done_pulses - base_done), 32'd1);
        check("t6 gap stray rx",   32'(bus.req_rxdata), 32'hDF);
        check("t6 gap busy",       32'(bus.busy), 32'h1);
        expect_completion("t6b", c);
        check("t6 first word kept", 32'(log_tx[li+1]), 32'hB400);
        check("t6 second ss_n",     32'(log_ss[li+1]), 32'h2);
        wait_idle("t6", n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_port_arbiter.md
Name: spi_port_arbiter

Overview:
Shares the single SPIinterface (transmit/txdata/rxdata/done) between NUM_REQ SPI requesters, for example two accelerometer masters, one per pong paddle. Each requester issues a one-word transaction. The block latches it, grants the shared bus round-robin, drives the matching device select, and returns the received byte or a timeout. It sits between the requester masters and the SPIinterface, and enforces the inter-transaction gap on the bus.

Parameters:
NUM_REQ, 2, number of requesters and device selects (2..4).
GAP_CYCLES, 4096, idle clk cycles enforced after each transaction (ADXL345 timing).
TIMEOUT_CYCLES, 65535, clk cycles to wait for spi_done before aborting.

Ports:
clk  in  1  system clock, 100 MHz.
rst  in  1  reset; asynchronous, active-high.
req_transmit  in  NUM_REQ  per-requester transaction request, sampled every clk.
req_txdata  in  16*NUM_REQ  per-requester 16-bit command word; slice i = [16i+15:16i].
req_done  out  NUM_REQ  one-cycle pulse: transaction for requester i completed.
req_timeout  out  NUM_REQ  one-cycle pulse: transaction for requester i aborted.
req_rxdata  out  8  last received byte; valid with req_done, held until the next completion.
spi_transmit  out  1  one-cycle start pulse to SPIinterface.
spi_txdata  out  16  command word to SPIinterface; held for the whole transaction.
spi_rxdata  in  8  received byte from SPIinterface.
spi_done  in  1  completion pulse from SPIinterface.
ss_n  out  NUM_REQ  active-low one-hot device select.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): every output is 0, except ss_n, which is all ones. State is IDLE, pending flags and shadow words are cleared, rr_ptr is 0, and both counters are 0. A reset mid-transaction releases ss_n immediately. No done or timeout pulse is produced for the aborted transaction.
- Request capture, every clk: if req_transmit[i]=1 and pending[i]=0, then pending[i] is set and shadow[i] captures that requester's slice of req_txdata.
  - If pending[i] is already 1, the request is ignored and the shadow word is not overwritten.
  - A requester may hold req_transmit high; it is re-captured once its pending flag clears.
- Arbitration: round-robin. Search starts at rr_ptr+1 mod NUM_REQ; the first requester with pending=1 wins. When several requesters are pending in the same cycle, this rotating order decides.
- States:
  - IDLE: if any requester is pending, latch grant g, load spi_txdata=shadow[g], drive ss_n[g]=0, go to ISSUE. Otherwise stay.
  - ISSUE: spi_transmit=1 for exactly this one cycle, clear the timeout counter, go to WAIT. ss_n therefore leads spi_transmit by at least one cycle.
  - WAIT: hold spi_txdata and ss_n.
    - If spi_done=1: req_rxdata<=spi_rxdata, pulse req_done[g], clear pending[g], rr_ptr<=g, ss_n<=all ones, go to GAP.
    - Else, if the counter equals TIMEOUT_CYCLES-1: pulse req_timeout[g], clear pending[g], rr_ptr<=g, ss_n<=all ones, go to GAP.
    - Otherwise increment the counter.
  - GAP: the gap counter counts 0..GAP_CYCLES-1, then the block goes to IDLE and clears the counter.
- Pulse timing: req_done and req_timeout are registered and high for exactly one cycle, in the cycle after the spi_done edge.
- spi_done while not in WAIT is ignored.
- Latency: request captured at edge N, grant at N+1, spi_transmit high during cycle N+2. Minimum spacing between spi_transmit pulses is GAP_CYCLES+2 cycles plus the SPI transaction time.
- A requester re-requesting during its own transaction is captured after its pending flag clears at completion. It is served no earlier than the next IDLE, subject to round-robin.
- Simultaneous capture and completion for the same requester: completion clears pending first, and capture applies from the following edge.
- Widths: both counters are 16 bits. GAP_CYCLES and TIMEOUT_CYCLES must be ≤ 65536 and ≥ 1.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_GAP=3;
  - the PmodACL command constants (POWER_CTL 16'h2D08, BW_RATE 16'h2C08, DATA_FORMAT 16'h3100, read words 16'hB400/16'hB500);
  - the default GAP and TIMEOUT values.
- One natural sub-module, rr_arbiter. It is combinational: it takes the pending vector and rr_ptr and returns a grant index and a valid flag. It is reused by any future shared-resource block.

Test Plan:
- Single requester: req_transmit[0] pulsed with txdata 16'hB400; the SPI model returns done after 40 cycles with rxdata 8'h5A. Required response:
  - ss_n=2'b10, spi_txdata=16'hB400, spi_transmit pulse 2 cycles after the request;
  - req_done=2'b01 pulse, req_rxdata=8'h5A;
  - ss_n=2'b11, busy low after 4096 gap cycles.
- Simultaneous requests: both requesters request at once with rr_ptr=0 (req0 16'h2D08, req1 16'hB500). Required response: req1 is served first, then req0. Each pair of spi_transmit pulses is separated by ≥ GAP_CYCLES+2 cycles.
- Fairness: both requesters hold req_transmit high continuously for 6 transactions. Required response: grants alternate 1,0,1,0,1,0 and there are exactly 6 req_done pulses.
- Timeout: the SPI model never asserts done, with TIMEOUT_CYCLES=100 for the test. Required response:
  - req_timeout[0] pulses exactly 100 cycles after spi_transmit;
  - req_done stays 0 and req_rxdata is unchanged;
  - the block returns to IDLE after the gap.
- Async reset: rst asserted mid-WAIT, between clock edges. Required response:
  - ss_n=all ones and busy=0 immediately;
  - no req_done or req_timeout pulse;
  - a new request after reset is served normally.
- Stray and duplicate events:
  - spi_done pulsed in IDLE and GAP: no output change.
  - A second req_transmit[0] with a different txdata while pending[0]=1: ignored, and the first word is transmitted unchanged.
